sram_controller: RTL and testbench

- Off-chip data-memory controller that sits directly downstream of the MEM stage and replaces the on-chip data RAM.
- Accepts one 32-bit load or store per request from the EXE/MEM pipeline register.
- Performs each access as two 16-bit transactions on an external 256K x 16 asynchronous SRAM.
- Drives `ready` low while busy; top level uses it to freeze every pipeline register and the PC.

---
 rtl/sram_controller.sv | 151 +++++++++++++++
 tb/tb_sram_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Off-chip data-memory controller placed after the MEM stage.
//            Each 32-bit load/store from the EXE/MEM register is carried out
//            as two 16-bit accesses (low halfword, then high halfword) on an
//            external 256K x 16 asynchronous SRAM. While an access is in
//            flight, ready is held low so the top level freezes the pipeline.
// Ports    : clk, rst (sync, active-low)
//            wr_en, rd_en, address, write_data  - request from EXE/MEM
//            read_data, ready                   - load result / pipeline freeze
//            SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
//            SRAM_DQ_in, SRAM_*_N strobes       - SRAM pad side
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,       // cycles per halfword, 1..15
    parameter logic [31:0] BASE_ADDR   = 32'd1024 // CPU address of SRAM word 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] addr_q;

    logic        w_req;
    logic        w_last;
    logic [16:0] w_word;

    assign w_req  = rd_en | wr_en;
    assign w_last = (cnt_q == C_LAST_CNT);
    // SRAM 32-bit word index: byte offset from BASE_ADDR, address bits [1:0]
    // ignored, offset bits above 18 dropped (no range check).
    assign w_word = 17'((address - BASE_ADDR) >> 2);

    assign read_data = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        SRAM_ADDR   = addr_q;   // idle pins keep the last address
        SRAM_DQ_out = 16'h0000;
        SRAM_DQ_oe  = 1'b0;
        SRAM_CE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        SRAM_WE_N   = 1'b1;
        SRAM_UB_N   = 1'b1;
        SRAM_LB_N   = 1'b1;

        // Shared pin setup for both halfword phases; wr_en wins over rd_en.
        if (state_q == S_LOW || state_q == S_HIGH) begin
            SRAM_CE_N   = 1'b0;
            SRAM_UB_N   = 1'b0;
            SRAM_LB_N   = 1'b0;
            SRAM_OE_N   = wr_en;
            SRAM_WE_N   = ~wr_en;
            SRAM_DQ_oe  = wr_en;
            SRAM_ADDR   = {w_word, (state_q == S_HIGH)};
            SRAM_DQ_out = (state_q == S_HIGH) ? write_data[31:16] : write_data[15:0];
        end

        case (state_q)
            S_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    state_d = S_LOW;
                    cnt_d   = 4'd0;
                end
            end
            S_LOW: begin
                if (w_last) begin
                    state_d = S_HIGH;
                    cnt_d   = 4'd0;
                    if (!wr_en) begin
                        rdata_d[15:0] = SRAM_DQ_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                    if (!wr_en) begin
                        rdata_d[31:16] = SRAM_DQ_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held nothing is pending, so the pipeline is not frozen.
        if (!rst) begin
            ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0000_0000;
            addr_q  <= 18'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= SRAM_ADDR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Self-checking bench for sram_controller. A transaction-level
//            model predicts the per-cycle pin/ready/read_data behaviour of each
//            request from its cycle index; a behavioural SRAM sits on the pads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
    logic        SRAM_DQ_oe;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_oe (SRAM_DQ_oe),
        .SRAM_DQ_in (SRAM_DQ_in),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    // Behavioural asynchronous SRAM (only the low 1K halfwords are modelled).
    logic [15:0] sram    [0:1023] = '{default: 16'h0000};
    logic [15:0] ref_mem [0:1023] = '{default: 16'h0000};

    assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[9:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe)
            sram[SRAM_ADDR[9:0]] <= SRAM_DQ_out;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for the current cycle, filled in by the stimulus tasks.
    logic        chk_en = 1'b0;
    logic        e_ready, e_ce_n, e_oe_n, e_we_n, e_ub_n, e_lb_n, e_dq_oe;
    logic        e_pins_v, e_dqout_v;
    logic [17:0] e_addr;
    logic [15:0] e_dqout;
    logic [31:0] e_rdata;

    logic [17:0] last_addr  = 18'd0;
    logic [31:0] prev_rdata = 32'd0;

    int we_cnt = 0, oe_cnt = 0, dqoe_cnt = 0;

    // Single compare process: checks every cycle the model has an expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'd0, ready}, {31'd0, e_ready});
            chk("read_data", read_data, e_rdata);
            if (e_pins_v) begin
                chk("CE_N", {31'd0, SRAM_CE_N}, {31'd0, e_ce_n});
                chk("OE_N", {31'd0, SRAM_OE_N}, {31'd0, e_oe_n});
                chk("WE_N", {31'd0, SRAM_WE_N}, {31'd0, e_we_n});
                chk("UB_N", {31'd0, SRAM_UB_N}, {31'd0, e_ub_n});
                chk("LB_N", {31'd0, SRAM_LB_N}, {31'd0, e_lb_n});
                chk("DQ_oe", {31'd0, SRAM_DQ_oe}, {31'd0, e_dq_oe});
                chk("SRAM_ADDR", {14'd0, SRAM_ADDR}, {14'd0, e_addr});
                if (e_dqout_v) chk("DQ_out", {16'd0, SRAM_DQ_out}, {16'd0, e_dqout});
            end
            if (!SRAM_WE_N) we_cnt++;
            if (!SRAM_OE_N) oe_cnt++;
            if (SRAM_DQ_oe) dqoe_cnt++;
        end
    end

    task automatic set_idle_pins();
        e_pins_v  = 1'b1;
        e_dqout_v = 1'b0;
        e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_ub_n = 1'b1; e_lb_n = 1'b1;
        e_dq_oe = 1'b0;
        e_addr  = last_addr;
        e_dqout = 16'h0000;
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_idle_pins();
            e_ready = 1'b1;
            e_rdata = prev_rdata;
            chk_en  = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // One request, cycle index k = 0 .. 2W+1: k=0 request seen in idle,
    // 1..W low halfword, W+1..2W high halfword, 2W+1 completion (ready=1).
    // abort_k >= 0 pulls rst low during that cycle instead of finishing.
    task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input int abort_k);
        logic [16:0] word;
        logic [17:0] lo, hi;
        logic [31:0] rd_val;
        word   = 17'((a - BASE) >> 2);
        lo     = {word, 1'b0};
        hi     = {word, 1'b1};
        rd_val = {ref_mem[hi[9:0]], ref_mem[lo[9:0]]};
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        for (int k = 0; k <= 2*W + 1; k++) begin
            if (!wr && k >= W + 1 && k <= 2*W) e_rdata = {prev_rdata[31:16], rd_val[15:0]};
            else if (!wr && k == 2*W + 1)     e_rdata = rd_val;
            else                              e_rdata = prev_rdata;

            if (k == abort_k) begin
                rst      = 1'b0;
                e_ready  = 1'b1;
                e_pins_v = 1'b0;
                chk_en   = 1'b1;
                @(posedge clk); #1;
                rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
                prev_rdata = 32'd0;
                last_addr  = 18'd0;
                return;
            end

            set_idle_pins();
            if (k == 0) begin
                e_ready = 1'b0;
            end else if (k <= 2*W) begin
                e_ready = 1'b0;
                e_ce_n = 1'b0; e_ub_n = 1'b0; e_lb_n = 1'b0;
                e_addr = (k <= W) ? lo : hi;
                if (wr) begin
                    e_oe_n = 1'b1; e_we_n = 1'b0; e_dq_oe = 1'b1;
                    e_dqout_v = 1'b1;
                    e_dqout = (k <= W) ? d[15:0] : d[31:16];
                end else begin
                    e_oe_n = 1'b0; e_we_n = 1'b1; e_dq_oe = 1'b0;
                end
            end else begin
                e_ready = 1'b1;
                e_addr  = hi;
            end
            chk_en = 1'b1;
            @(posedge clk); #1;
        end
        if (wr) begin
            ref_mem[lo[9:0]] = d[15:0];
            ref_mem[hi[9:0]] = d[31:16];
        end else begin
            prev_rdata = rd_val;
        end
        last_addr = hi;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    int we_base, oe_base, dq_base;

    initial begin
        rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0;
        address = 32'd1024; write_data = 32'd0;

        // Reset held two cycles with a pending load request.
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            set_idle_pins();
            e_ready = 1'b1;
            e_rdata = 32'd0;
            chk_en  = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        idle(2);

        // Store 0xDEADBEEF to 1024.
        we_base = we_cnt;
        do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1);
        chk("sram[0]", {16'd0, sram[0]}, 32'h0000_BEEF);
        chk("sram[1]", {16'd0, sram[1]}, 32'h0000_DEAD);
        chk("WE_N low cycles", we_cnt - we_base, 32'd4);
        idle(1);

        // Load it back.
        oe_base = oe_cnt; dq_base = dqoe_cnt;
        do_req(1'b0, 1'b1, 32'd1024, 32'd0, -1);
        chk("load 1024", read_data, 32'hDEADBEEF);
        chk("OE_N low cycles", oe_cnt - oe_base, 32'd4);
        chk("DQ_oe cycles on load", dqoe_cnt - dq_base, 32'd0);
        idle(1);

        // Address map, aligned and unaligned.
        do_req(1'b1, 1'b0, 32'd1036, 32'h12345678, -1);
        chk("sram[6]", {16'd0, sram[6]}, 32'h0000_5678);
        chk("sram[7]", {16'd0, sram[7]}, 32'h0000_1234);
        do_req(1'b1, 1'b0, 32'd1037, 32'hCAFEF00D, -1);
        chk("sram[6] unaligned", {16'd0, sram[6]}, 32'h0000_F00D);
        chk("sram[7] unaligned", {16'd0, sram[7]}, 32'h0000_CAFE);
        idle(1);

        // Back-to-back store then load at 1028.
        do_req(1'b1, 1'b0, 32'd1028, 32'hA5A55A5A, -1);
        do_req(1'b0, 1'b1, 32'd1028, 32'd0, -1);
        chk("load 1028", read_data, 32'hA5A55A5A);
        chk("sram[2]", {16'd0, sram[2]}, 32'h0000_5A5A);
        idle(1);

        // Reset in the second HIGH cycle of a read.
        do_req(1'b0, 1'b1, 32'd1024, 32'd0, 2*W);
        idle(1);
        chk("read_data after abort", read_data, 32'd0);

        // Both enables asserted: performs a write.
        do_req(1'b1, 1'b1, 32'd1040, 32'h0BADC0DE, -1);
        chk("sram[8]", {16'd0, sram[8]}, 32'h0000_C0DE);
        chk("sram[9]", {16'd0, sram[9]}, 32'h0000_0BAD);
        chk("read_data after rd+wr", read_data, 32'd0);
        idle(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
